// File: rtl/ieee_fp_pkg.sv
// ---------------------------------------------------------------------------
// ieee_fp_pkg : shared IEEE-754 field widths, biases and converter state codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ieee_fp_pkg;

  localparam int D_EXP_W  = 11;
  localparam int D_MANT_W = 52;
  localparam int F_EXP_W  = 8;
  localparam int F_MANT_W = 23;

  localparam int D_BIAS = 1023;
  localparam int F_BIAS = 127;
  localparam int F_EMIN = -126;

  // Unbiased exponent width; holds every double exponent plus rounding carry.
  localparam int E_W = 12;

  localparam logic [31:0] F_QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DENORM = 3'd2,
    ST_ROUND  = 3'd3,
    ST_PACK   = 3'd4,
    ST_PUT_Z  = 3'd5
  } d2f_state_e;

  function automatic logic [31:0] f_inf(input logic s);
    return {s, {F_EXP_W{1'b1}}, {F_MANT_W{1'b0}}};
  endfunction

  function automatic logic [31:0] f_zero(input logic s);
    return {s, {(F_EXP_W + F_MANT_W){1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/float_round_pack.sv
// ---------------------------------------------------------------------------
// float_round_pack : RNE increment, carry renormalise, overflow and field pack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module float_round_pack
  import ieee_fp_pkg::*;
(
  input  logic                  sign_i,
  input  logic signed [E_W-1:0] exp_i,
  input  logic [F_MANT_W:0]     mant_i,
  input  logic                  guard_i,
  input  logic                  round_i,
  input  logic                  sticky_i,
  output logic [F_MANT_W:0]     mant_o,
  output logic signed [E_W-1:0] exp_o,
  output logic [31:0]           z_o
);

  localparam logic signed [E_W-1:0] E_MAX = E_W'(F_BIAS);

  logic                  inc;
  logic [F_MANT_W+1:0]   sum;
  logic [F_EXP_W-1:0]    exp_field;

  always_comb begin
    inc    = guard_i & (round_i | sticky_i | mant_i[0]);
    sum    = {1'b0, mant_i} + {{(F_MANT_W + 1){1'b0}}, inc};
    mant_o = sum[F_MANT_W:0];
    exp_o  = exp_i;
    if (sum[F_MANT_W+1]) begin
      mant_o = {1'b1, {F_MANT_W{1'b0}}};
      exp_o  = exp_i + E_W'(1);
    end

    // Only meaningful when exp_o lies in the normal range, where it cannot wrap.
    exp_field = exp_o[F_EXP_W-1:0] + F_EXP_W'(F_BIAS);

    if (exp_o > E_MAX) begin
      z_o = f_inf(sign_i);
    end else if (!mant_o[F_MANT_W]) begin
      z_o = {sign_i, {F_EXP_W{1'b0}}, mant_o[F_MANT_W-1:0]};
    end else begin
      z_o = {sign_i, exp_field, mant_o[F_MANT_W-1:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/double_to_float.sv
// ---------------------------------------------------------------------------
// double_to_float : IEEE-754 double to single, RNE, on stb/ack operand links
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module double_to_float
  import ieee_fp_pkg::*;
#(
  parameter logic [31:0] QNAN         = F_QNAN,
  parameter bit          FLUSH_DENORM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic signed [E_W-1:0] E_MAX  = E_W'(F_BIAS);
  localparam logic signed [E_W-1:0] E_MIN  = E_W'(F_EMIN);
  localparam logic signed [E_W-1:0] E_TINY = E_W'(F_EMIN - F_MANT_W - 1);
  localparam logic signed [E_W-1:0] E_DOFF = E_W'(D_BIAS);

  d2f_state_e            state_q, state_d;
  logic [63:0]           a_q, a_d;
  logic                  s_q, s_d;
  logic signed [E_W-1:0] e_q, e_d;
  logic [F_MANT_W:0]     m_q, m_d;
  logic                  g_q, g_d;
  logic                  r_q, r_d;
  logic                  st_q, st_d;
  logic [31:0]           z_q, z_d;
  logic                  ack_q, ack_d;
  logic                  stb_q, stb_d;

  logic [D_EXP_W-1:0]    a_exp;
  logic [D_MANT_W-1:0]   a_mant;
  logic signed [E_W-1:0] a_e;

  logic [F_MANT_W:0]     rp_mant;
  logic signed [E_W-1:0] rp_exp;
  logic [31:0]           rp_z;

  assign a_exp  = a_q[D_EXP_W+D_MANT_W-1:D_MANT_W];
  assign a_mant = a_q[D_MANT_W-1:0];
  assign a_e    = $signed({1'b0, a_exp}) - E_DOFF;

  float_round_pack u_round_pack (
    .sign_i   (s_q),
    .exp_i    (e_q),
    .mant_i   (m_q),
    .guard_i  (g_q),
    .round_i  (r_q),
    .sticky_i (st_q),
    .mant_o   (rp_mant),
    .exp_o    (rp_exp),
    .z_o      (rp_z)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    e_d     = e_q;
    m_d     = m_q;
    g_d     = g_q;
    r_d     = r_q;
    st_d    = st_q;
    z_d     = z_q;
    ack_d   = 1'b0;

    unique case (state_q)
      ST_GET_A: begin
        ack_d = 1'b1;
        if (input_a_stb && ack_q) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        s_d     = a_q[63];
        e_d     = a_e;
        m_d     = {1'b1, a_mant[D_MANT_W-1:D_MANT_W-F_MANT_W]};
        g_d     = a_mant[D_MANT_W-F_MANT_W-1];
        r_d     = a_mant[D_MANT_W-F_MANT_W-2];
        st_d    = |a_mant[D_MANT_W-F_MANT_W-3:0];
        state_d = ST_DENORM;
        // Specials bypass the rounding datapath and go straight to the output.
        if (a_exp == {D_EXP_W{1'b1}}) begin
          z_d     = (a_mant != '0) ? QNAN : f_inf(a_q[63]);
          state_d = ST_PUT_Z;
        end else if (a_exp == '0) begin
          z_d     = f_zero(a_q[63]);
          state_d = ST_PUT_Z;
        end else if (a_e > E_MAX) begin
          z_d     = f_inf(a_q[63]);
          state_d = ST_PUT_Z;
        end else if (a_e < E_TINY || (FLUSH_DENORM && a_e < E_MIN)) begin
          z_d     = f_zero(a_q[63]);
          state_d = ST_PUT_Z;
        end
      end

      ST_DENORM: begin
        if (e_q < E_MIN) begin
          st_d = st_q | r_q;
          r_d  = g_q;
          g_d  = m_q[0];
          m_d  = m_q >> 1;
          e_d  = e_q + E_W'(1);
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        m_d     = rp_mant;
        e_d     = rp_exp;
        g_d     = 1'b0;
        r_d     = 1'b0;
        st_d    = 1'b0;
        state_d = ST_PACK;
      end

      ST_PACK: begin
        // Round bits are clear now, so the sub-module only packs the fields.
        z_d     = rp_z;
        state_d = ST_PUT_Z;
      end

      ST_PUT_Z: begin
        if (output_z_ack) begin
          state_d = ST_GET_A;
        end
      end

      default: begin
        state_d = ST_GET_A;
      end
    endcase
  end

  assign stb_d = (state_d == ST_PUT_Z);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_GET_A;
      a_q     <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      st_q    <= 1'b0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      e_q     <= e_d;
      m_q     <= m_d;
      g_q     <= g_d;
      r_q     <= r_d;
      st_q    <= st_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;

endmodule

`default_nettype wire

// File: tb/tb_double_to_float.sv
// ---------------------------------------------------------------------------
// tb_double_to_float : directed and random checks of double_to_float
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_double_to_float;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_a    [2];
  logic        in_stb  [2];
  logic        in_ack  [2];
  logic [31:0] out_z   [2];
  logic        out_stb [2];
  logic        out_ack [2];

  int n_cmp;
  int n_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  double_to_float #(.FLUSH_DENORM(1'b0)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (in_a[0]),
    .input_a_stb  (in_stb[0]),
    .input_a_ack  (in_ack[0]),
    .output_z     (out_z[0]),
    .output_z_stb (out_stb[0]),
    .output_z_ack (out_ack[0])
  );

  double_to_float #(.FLUSH_DENORM(1'b1)) u_dut_flush (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (in_a[1]),
    .input_a_stb  (in_stb[1]),
    .input_a_ack  (in_ack[1]),
    .output_z     (out_z[1]),
    .output_z_stb (out_stb[1]),
    .output_z_ack (out_ack[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Exact value model: round the full double significand to the single grid.
  function automatic void model(input logic [63:0] a, input bit flush,
                                output logic [31:0] z, output int lat);
    logic              s;
    int                ex;
    int                e;
    int                q;
    int                sh;
    longint unsigned   frac;
    longint unsigned   sig;
    longint unsigned   n;
    longint unsigned   rem;
    longint unsigned   half;
    s    = a[63];
    ex   = int'(a[62:52]);
    frac = longint'(a[51:0]);
    e    = ex - 1023;
    lat  = 1;
    if (ex == 2047)                z = (frac != 0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
    else if (ex == 0)              z = {s, 31'h0};
    else if (e > 127)              z = {s, 8'hFF, 23'h0};
    else if (e < -150)             z = {s, 31'h0};
    else if (flush && e < -126)    z = {s, 31'h0};
    else begin
      sig  = (64'd1 << 52) | frac;
      q    = ((e < -126) ? -126 : e) - 23;
      sh   = q - (e - 52);
      n    = sig >> sh;
      rem  = sig - (n << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && n[0])) n = n + 1;
      if (n == (64'd1 << 24)) begin
        n = n >> 1;
        q = q + 1;
      end
      lat = (e < -126) ? 4 + (-126 - e) : 4;
      if (q + 23 > 127)               z = {s, 8'hFF, 23'h0};
      else if (n < (64'd1 << 23))     z = {s, 8'h00, n[22:0]};
      else                            z = {s, 8'(q + 23 + 127), n[22:0]};
    end
  endfunction

  task automatic launch(input int i, input logic [63:0] a);
    int n;
    n = 0;
    in_a[i]   = a;
    in_stb[i] = 1'b1;
    while (!in_ack[i] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_wait", {63'd0, in_ack[i]}, 64'd1);
    @(posedge clk); #1;
    in_stb[i] = 1'b0;
  endtask

  task automatic wait_result(input int i, output int lat);
    lat = 0;
    while (!out_stb[i] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input int i);
    out_ack[i] = 1'b1;
    @(posedge clk); #1;
    out_ack[i] = 1'b0;
    chk("drop", {62'd0, out_stb[i], in_ack[i]}, 64'd0);
  endtask

  task automatic conv(input int i, input logic [63:0] a, input logic [31:0] zexp,
                      input int lexp, input string tag);
    int lat;
    launch(i, a);
    wait_result(i, lat);
    chk({tag, "/val"}, {32'd0, out_z[i]}, {32'd0, zexp});
    chk({tag, "/lat"}, 64'(lat), 64'(lexp));
    consume(i);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_a[i]    = '0;
      in_stb[i]  = 1'b0;
      out_ack[i] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #1;
    chk("rst0", {29'd0, in_ack[0], out_stb[0], out_z[0], 2'b0}, 64'd0);
    chk("rst1", {29'd0, in_ack[1], out_stb[1], out_z[1], 2'b0}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", {62'd0, in_ack[0], in_ack[1]}, 64'd3);

    conv(0, 64'h3FF0000000000000, 32'h3F800000, 4,  "one");
    conv(0, 64'h3FF0000010000000, 32'h3F800000, 4,  "tie_even");
    conv(0, 64'h3FF0000030000000, 32'h3F800002, 4,  "tie_up");
    conv(0, 64'h47EFFFFFF0000000, 32'h7F800000, 4,  "ovf_carry");
    conv(0, 64'h47F0000000000000, 32'h7F800000, 1,  "ovf_exp");
    conv(0, 64'h36A0000000000000, 32'h00000001, 27, "min_sub");
    conv(0, 64'h3690000000000000, 32'h00000000, 28, "half_min");
    conv(0, 64'h380FFFFFF0000000, 32'h00800000, 5,  "sub_to_norm");
    conv(0, 64'h8000000000000000, 32'h80000000, 1,  "neg_zero");
    conv(0, 64'hFFF0000000000000, 32'hFF800000, 1,  "neg_inf");
    conv(0, 64'h7FF8000000000001, 32'h7FC00000, 1,  "nan");
    conv(1, 64'h36A0000000000000, 32'h00000000, 1,  "flush_sub");
    conv(1, 64'h3FF0000000000000, 32'h3F800000, 4,  "flush_one");

    // Back-pressure: result held, operand side closed, stray strobes ignored.
    launch(0, 64'hC000000000000000);
    wait_result(0, lat);
    chk("bp/val", {32'd0, out_z[0]}, 64'h00000000C0000000);
    for (int c = 0; c < 10; c++) begin
      in_stb[0] = c[0];
      in_a[0]   = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp/hold", {30'd0, out_stb[0], out_z[0], in_ack[0]}, {30'd0, 1'b1, 32'hC0000000, 1'b0});
    end
    in_stb[0] = 1'b0;
    consume(0);
    conv(0, 64'h3FF0000000000000, 32'h3F800000, 4, "after_bp");

    // Reset while shifting a subnormal, then a clean conversion.
    launch(0, 64'h36A0000000000000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort", {29'd0, in_ack[0], out_stb[0], out_z[0], 2'b0}, 64'd0);
    rst_n = 1'b1;
    conv(0, 64'h4009000000000000, 32'h40480000, 4, "after_rst");

    for (int k = 0; k < 80; k++) begin
      int          sel;
      int          inst;
      int          lm;
      logic [63:0] a;
      logic [31:0] zm;
      inst = (k % 5 == 4) ? 1 : 0;
      a    = {$urandom, $urandom};
      sel  = int'($urandom_range(0, 9));
      if (sel == 0) begin
        a[62:52] = 11'h7FF;
        if ($urandom_range(0, 1) == 0) a[51:0] = '0;
      end else if (sel == 1) begin
        a[62:52] = 11'h000;
      end else begin
        a[62:52] = 11'(863 + $urandom_range(0, 290));
      end
      if ($urandom_range(0, 3) == 0) a[28:0] = 29'h10000000;
      model(a, inst == 1, zm, lm);
      conv(inst, a, zm, lm, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
